// File: rtl/reg_native_to_apb.sv
// rtl/reg_native_to_apb.sv - reg_native request to APB master bridge
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module reg_native_to_apb #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  fsm_clk,
  input  logic                  fsm_rstn,
  input  logic                  global_sync_reset_in,
  input  logic                  req_vld,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  ack_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  slv_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  slv_err_q, slv_err_d;
  logic                  timeout;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge fsm_clk or negedge fsm_rstn) begin
    if (!fsm_rstn) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      rd_data_q <= '0;
      slv_err_q <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      rd_data_q <= rd_data_d;
      slv_err_q <= slv_err_d;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    rd_data_d = rd_data_q;
    slv_err_d = slv_err_q;
`ifdef APB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_vld) begin
          if (wr_en ^ rd_en) begin
            paddr_d  = addr;
            pwdata_d = wr_data;
            pwrite_d = wr_en;
            state_d  = SETUP;
          end else begin
            // Ambiguous request type: answer with an error without touching APB
            rd_data_d = '0;
            slv_err_d = 1'b1;
            state_d   = RESP;
          end
        end
      end
      SETUP: begin
`ifdef APB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = ACCESS;
      end
      ACCESS: begin
`ifdef APB_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        if (PREADY) begin
          rd_data_d = pwrite_q ? '0 : PRDATA;
          slv_err_d = PSLVERR;
          state_d   = RESP;
        end else if (timeout) begin
          rd_data_d = '0;
          slv_err_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        rd_data_d = '0;
        slv_err_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (global_sync_reset_in) begin
      state_d   = IDLE;
      paddr_d   = '0;
      pwdata_d  = '0;
      pwrite_d  = 1'b0;
      rd_data_d = '0;
      slv_err_d = 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_d     = '0;
`endif
    end
  end

  assign PSEL    = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE = (state_q == ACCESS);
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PWRITE  = pwrite_q;
  assign ack_vld = (state_q == RESP);
  assign rd_data = ack_vld ? rd_data_q : '0;
  assign slv_err = ack_vld ? slv_err_q : 1'b0;

endmodule

// File: tb/tb_reg_native_to_apb.sv
// tb/tb_reg_native_to_apb.sv - scoreboard bench for reg_native_to_apb
module tb_reg_native_to_apb;

  logic        fsm_clk = 1'b0;
  logic        fsm_rstn = 1'b0;
  logic        global_sync_reset_in = 1'b0;
  logic        req_vld = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [63:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic        ack_vld, slv_err;
  logic [31:0] rd_data;
  logic        PSEL, PENABLE, PWRITE;
  logic [63:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0, PSLVERR = 1'b0;

  reg_native_to_apb #(.ADDR_WIDTH(64), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .fsm_clk(fsm_clk), .fsm_rstn(fsm_rstn), .global_sync_reset_in(global_sync_reset_in),
    .req_vld(req_vld), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data),
    .ack_vld(ack_vld), .rd_data(rd_data), .slv_err(slv_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 fsm_clk = ~fsm_clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          at;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_pass = 0, n_total = 0;
  int          ws = 0;
  int          acc_n = 0;
  logic [63:0] exp_addr = '0;
  logic [31:0] exp_wdata = '0;
  logic        exp_wr = 1'b0;

  always @(posedge fsm_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // APB slave: PREADY rises in the (ws+1)-th ACCESS cycle
  always @(negedge fsm_clk) begin
    if (PSEL && PENABLE) begin
      PREADY = (acc_n == ws);
      acc_n++;
    end else begin
      acc_n = 0;
      PREADY = 1'b0;
    end
  end

  always @(negedge fsm_clk) begin
    if (fsm_rstn && ack_vld) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_cycle", cyc, e.at);
        chk("rd_data", rd_data, e.rd);
        chk("slv_err", slv_err, e.err);
      end
    end else if (fsm_rstn) begin
      chk("idle_outputs", {rd_data, slv_err}, 33'h0);
    end
    if (fsm_rstn && PSEL) begin
      chk("paddr_stable", PADDR, exp_addr);
      chk("pwdata_stable", PWDATA, exp_wdata);
      chk("pwrite_stable", PWRITE, exp_wr);
    end
  end

  task automatic issue(input logic w, input logic r, input logic [63:0] a, input logic [31:0] d,
                       input bit push, input int lat, input logic [31:0] erd, input logic eerr);
    @(posedge fsm_clk); #1;
    req_vld = 1'b1; wr_en = w; rd_en = r; addr = a; wr_data = d;
    if (w ^ r) begin
      exp_addr = a; exp_wdata = d; exp_wr = w;
    end
    if (push) sb.push_back('{erd, eerr, cyc + lat});
    @(posedge fsm_clk); #1;
    req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge fsm_clk);
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #1;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_ack", ack_vld, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwrite", PWRITE, 0);
    repeat (3) @(posedge fsm_clk);
    #1 fsm_rstn = 1'b1;

    // Zero-wait write; PRDATA ignored on writes
    ws = 0; PRDATA = 32'hA5A5_A5A5;
    issue(1, 0, 64'h10, 32'hFFFF_FFFF, 1, 3, 32'h0, 1'b0);
    @(negedge fsm_clk);
    chk("setup_psel", PSEL, 1);
    chk("setup_penable", PENABLE, 0);
    @(negedge fsm_clk);
    chk("access_penable", PENABLE, 1);
    drain(20);

    // Read with 3 wait states; a second req_vld during ACCESS is ignored
    ws = 3; PRDATA = 32'h1234_5678;
    issue(0, 1, 64'h14, 32'h0, 1, 6, 32'h1234_5678, 1'b0);
    @(posedge fsm_clk); #1;
    req_vld = 1'b1; wr_en = 1'b1; addr = 64'h99; wr_data = 32'h5555_5555;
    @(posedge fsm_clk); #1;
    req_vld = 1'b0; wr_en = 1'b0;
    drain(20);
    repeat (4) @(posedge fsm_clk);

    // Read completing with PSLVERR
    ws = 1; PRDATA = 32'hDEAD_BEEF; PSLVERR = 1'b1;
    issue(0, 1, 64'h20, 32'h0, 1, 4, 32'hDEAD_BEEF, 1'b1);
    drain(20);
    PSLVERR = 1'b0;

    // Both and neither request types: error ack without APB
    issue(1, 1, 64'h30, 32'h1, 1, 1, 32'h0, 1'b1);
    @(negedge fsm_clk);
    chk("both_no_psel", PSEL, 0);
    drain(10);
    issue(0, 0, 64'h34, 32'h1, 1, 1, 32'h0, 1'b1);
    @(negedge fsm_clk);
    chk("neither_no_psel", PSEL, 0);
    drain(10);

    // Soft reset during ACCESS aborts without ack
    ws = 100;
    issue(0, 1, 64'h40, 32'h0, 0, 0, 32'h0, 1'b0);
    @(negedge fsm_clk);
    @(negedge fsm_clk);
    chk("sr_in_access", PENABLE, 1);
    @(posedge fsm_clk); #1 global_sync_reset_in = 1'b1;
    @(posedge fsm_clk); #1 global_sync_reset_in = 1'b0;
    @(negedge fsm_clk);
    chk("sr_psel", PSEL, 0);
    chk("sr_paddr", PADDR, 0);
    repeat (5) @(posedge fsm_clk);
    ws = 0;
    issue(1, 0, 64'h44, 32'hCAFE_0001, 1, 3, 32'h0, 1'b0);
    drain(20);

    // Soft reset overrides a simultaneous request
    @(posedge fsm_clk); #1;
    global_sync_reset_in = 1'b1; req_vld = 1'b1; wr_en = 1'b1; addr = 64'h50;
    @(posedge fsm_clk); #1;
    global_sync_reset_in = 1'b0; req_vld = 1'b0; wr_en = 1'b0;
    @(negedge fsm_clk);
    chk("sr_override_psel", PSEL, 0);
    chk("sr_override_ack", ack_vld, 0);
    repeat (4) @(posedge fsm_clk);

    // Async reset mid-transfer
    ws = 100;
    issue(0, 1, 64'h60, 32'h0, 0, 0, 32'h0, 1'b0);
    @(negedge fsm_clk);
    @(negedge fsm_clk);
    fsm_rstn = 1'b0;
    #1;
    chk("arst_psel", PSEL, 0);
    chk("arst_penable", PENABLE, 0);
    @(posedge fsm_clk); #1 fsm_rstn = 1'b1;
    repeat (5) @(posedge fsm_clk);

`ifdef APB_TIMEOUT_EN
    ws = 1000;
    issue(0, 1, 64'h70, 32'h0, 1, 10, 32'h0, 1'b1);
    drain(30);
`else
    ws = 1000;
    issue(0, 1, 64'h70, 32'h0, 0, 0, 32'h0, 1'b0);
    repeat (20) @(negedge fsm_clk);
    chk("no_timeout_wait", PENABLE, 1);
    @(posedge fsm_clk); #1 global_sync_reset_in = 1'b1;
    @(posedge fsm_clk); #1 global_sync_reset_in = 1'b0;
`endif
    ws = 0;
    repeat (5) @(posedge fsm_clk);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
